// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner: FSM states,
// key-code type, column/row idle values and the row/column -> hex key map.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   typedef logic [3:0] key_t;

   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam logic [3:0] ROW_IDLE  = 4'b1111;

   // Nibble index = {row, col}; entry 0 (row 0, col 0) sits in the least significant nibble.
   localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

   function automatic key_t key_lookup(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/keypad_if.sv
// Key delivery port of the keypad scanner (valid/ready plus sticky overrun).
// The 32-bit digit history "word" exists only when KEYPAD_WORD_EN is defined.
interface keypad_if;
   import keypad_pkg::*;

   logic key_valid;
   logic key_ready;
   key_t key_code;
   logic overrun;
`ifdef KEYPAD_WORD_EN
   logic [31:0] word;
`endif

   modport master (
      input  key_ready,
      output key_valid,
      output key_code,
      output overrun
`ifdef KEYPAD_WORD_EN
      , output word
`endif
   );

   modport slave (
      output key_ready,
      input  key_valid,
      input  key_code,
      input  overrun
`ifdef KEYPAD_WORD_EN
      , input word
`endif
   );

endinterface

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser for the asynchronous, active-low keypad row returns.
// Resets to all rows idle so no phantom key is seen coming out of reset.
module keypad_sync2
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] row_p0;
   logic [3:0] row_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         row_p0 <= ROW_IDLE;
         row_p1 <= ROW_IDLE;
      end else begin
         row_p0 <= d;
         row_p1 <= row_p0;
      end
   end

   assign q = row_p1;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: column strobing, debounce FSM and valid/ready key delivery.
// Define KEYPAD_WORD_EN to add the shift register of the last eight accepted digits.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
)
(
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] COL,
   input  logic [3:0] ROW,
   keypad_if.master   kif
);

   localparam int                CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam int                DB_W      = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DB_W-1:0]   DB_TARGET = DB_W'(DEBOUNCE_SCANS);

   logic [3:0]       row_s;
   logic [CNT_W-1:0] cnt;
   logic             sample;
   state_t           state, state_nxt;
   key_t             cand, sample_code, accept_code;
   logic [DB_W-1:0]  deb_cnt, deb_nxt;
   logic             hit, deb_done, load_cand, accept, advance, take;
   logic [2:0]       row_dec;
   logic [1:0]       col_idx;
   logic             key_valid, overrun;
   key_t             key_code;

   // Returns {hit, row index}; only a single low row bit counts as a key.
   function automatic logic [2:0] decode_row(input logic [3:0] r);
      case (r)
         4'b1110: return 3'b100;
         4'b1101: return 3'b101;
         4'b1011: return 3'b110;
         4'b0111: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [1:0] col_index(input logic [3:0] c);
      case (c)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   keypad_sync2 u_sync (.clk(clk), .reset(reset), .d(ROW), .q(row_s));

   assign sample      = (cnt == CNT_LAST);
   assign row_dec     = decode_row(row_s);
   assign hit         = row_dec[2];
   assign col_idx     = col_index(COL);
   assign sample_code = key_lookup(row_dec[1:0], col_idx);
   assign deb_done    = ((deb_cnt + DB_W'(1)) == DB_TARGET);

   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else       cnt <= sample ? '0 : cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= SCAN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (sample) begin
         case (state)
            SCAN:     if (hit) state_nxt = (DEBOUNCE_SCANS == 1) ? HELD : DEBOUNCE;
            DEBOUNCE: begin
               if (hit && sample_code == cand) begin
                  if (deb_done) state_nxt = HELD;
               end else begin
                  state_nxt = SCAN;
               end
            end
            HELD:     if (!hit && deb_done) state_nxt = SCAN;
            default:  state_nxt = SCAN;
         endcase
      end
   end

   // In HELD the debounce counter tracks consecutive no-key samples instead of matches.
   always_comb begin
      load_cand   = 1'b0;
      accept      = 1'b0;
      advance     = 1'b0;
      deb_nxt     = deb_cnt;
      accept_code = cand;
      if (sample) begin
         case (state)
            SCAN: begin
               if (!hit) begin
                  advance = 1'b1;
               end else begin
                  load_cand = 1'b1;
                  deb_nxt   = DB_W'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     accept      = 1'b1;
                     accept_code = sample_code;
                     deb_nxt     = '0;
                  end
               end
            end
            DEBOUNCE: begin
               if (hit && sample_code == cand) begin
                  if (deb_done) begin
                     accept  = 1'b1;
                     deb_nxt = '0;
                  end else begin
                     deb_nxt = deb_cnt + DB_W'(1);
                  end
               end else begin
                  advance = 1'b1;
               end
            end
            HELD: begin
               if (hit) begin
                  deb_nxt = '0;
               end else if (deb_done) begin
                  advance = 1'b1;
                  deb_nxt = '0;
               end else begin
                  deb_nxt = deb_cnt + DB_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         COL     <= COL_RESET;
         deb_cnt <= '0;
      end else begin
         if (advance) COL <= {COL[2:0], COL[3]};
         deb_cnt <= deb_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (load_cand) cand <= sample_code;
   end

   // A key is only dropped when the previous one is still pending and not being taken now.
   assign take = accept && (!key_valid || kif.key_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         key_valid <= 1'b0;
         key_code  <= '0;
         overrun   <= 1'b0;
      end else begin
         if (take) begin
            key_code  <= accept_code;
            key_valid <= 1'b1;
         end else if (kif.key_ready) begin
            key_valid <= 1'b0;
         end
         if (accept && !take) overrun <= 1'b1;
      end
   end

   assign kif.key_valid = key_valid;
   assign kif.key_code  = key_code;
   assign kif.overrun   = overrun;

`ifdef KEYPAD_WORD_EN
   logic [31:0] word;

   always_ff @(posedge clk) begin
      if (reset)     word <= '0;
      else if (take) word <= {word[27:0], accept_code};
   end

   assign kif.word = word;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=2) with a behavioural 4x4 keypad model.
// Word-register checks are active only when KEYPAD_WORD_EN is defined.
module tb_keypad_scan;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] COL;
   logic [3:0] ROW;

   logic       press_en  = 1'b0;
   logic [1:0] press_r   = 2'd0;
   logic [1:0] press_c   = 2'd0;
   logic       force_en  = 1'b0;
   logic [3:0] force_val = 4'hF;
   logic [1:0] phase;

   int checks = 0;
   int errors = 0;
   int n;
   int pulses;
   int bad;
   logic [3:0] exp_col;

   keypad_if kif ();

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .COL   (COL),
      .ROW   (ROW),
      .kif   (kif)
   );

   always #5 clk = ~clk;

   // Pressed key pulls its row low only while its column is strobed.
   always_comb begin
      ROW = 4'hF;
      if (force_en)                         ROW = force_val;
      else if (press_en && !COL[press_c])   ROW[press_r] = 1'b0;
   end

   // Reference dwell phase: 0 right after reset, 3 on the sample cycle.
   always @(posedge clk) begin
      if (reset) phase <= 2'd0;
      else       phase <= phase + 2'd1;
   end

   function automatic logic [3:0] rotl(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

   function automatic logic [3:0] col_of(input logic [1:0] c);
      logic [3:0] one_hot;
      one_hot = 4'b0001 << c;
      return ~one_hot;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_key(input string tag, input logic [3:0] code, input logic [3:0] col);
      int k;
      k = 0;
      while (kif.key_valid !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_seen"},  32'(kif.key_valid), 32'd1);
      check({tag, "_code"},  32'(kif.key_code), 32'(code));
      check({tag, "_col"},   32'(COL), 32'(col));
      check({tag, "_phase"}, 32'(phase), 32'd0);
   endtask

   task automatic wait_leave(input string tag, input logic [3:0] col, output int cycles);
      cycles = 0;
      while (COL === col && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
      check({tag, "_left"}, 32'(COL !== col), 32'd1);
   endtask

   task automatic wait_col_phase0(input string tag, input logic [3:0] col);
      int k;
      k = 0;
      while (!(COL === col && phase == 2'd0) && k < 64) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_align"}, 32'(COL === col && phase == 2'd0), 32'd1);
   endtask

   initial begin
      kif.key_ready = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("rst_col",     32'(COL), 32'(4'b1110));
      check("rst_valid",   32'(kif.key_valid), 32'd0);
      check("rst_code",    32'(kif.key_code), 32'd0);
      check("rst_overrun", 32'(kif.overrun), 32'd0);
`ifdef KEYPAD_WORD_EN
      check("rst_word",    kif.word, 32'd0);
`endif

      // Idle scan: one column step every 4 cycles
      exp_col = 4'b1110;
      for (int i = 0; i < 10; i++) begin
         repeat (4) @(negedge clk);
         exp_col = rotl(exp_col);
         check("scan_col",   32'(COL), 32'(exp_col));
         check("scan_valid", 32'(kif.key_valid), 32'd0);
      end

      // Held key 6 (row 1, column 2): single pulse, column frozen until release debounced
      press_r = 2'd1; press_c = 2'd2; press_en = 1'b1;
      wait_key("k6", 4'h6, 4'b1011);
      @(negedge clk);
      check("k6_xfer", 32'(kif.key_valid), 32'd0);
      pulses = 0; bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (kif.key_valid === 1'b1) pulses++;
         if (COL !== 4'b1011) bad++;
      end
      check("k6_no_repeat", 32'(pulses), 32'd0);
      check("k6_frozen",    32'(bad), 32'd0);
      press_en = 1'b0;
      wait_leave("k6_rel", 4'b1011, n);
      check("k6_next_col",  32'(COL), 32'(4'b0111));
      check("k6_rel_time",  32'(n >= 7 && n <= 10), 32'd1);

      // Bounce: hit on one sample only, then no-key
      wait_col_phase0("bounce", 4'b1101);
      press_r = 2'd0; press_c = 2'd1; press_en = 1'b1;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (kif.key_valid === 1'b1) pulses++;
      end
      check("bounce_frozen", 32'(COL), 32'(4'b1101));
      press_en = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (kif.key_valid === 1'b1) pulses++;
      end
      check("bounce_resume",   32'(COL), 32'(4'b1011));
      check("bounce_no_valid", 32'(pulses), 32'd0);

      // Consumer stalled: key 1 pending, key D dropped with overrun
      kif.key_ready = 1'b0;
      press_r = 2'd0; press_c = 2'd0; press_en = 1'b1;
      wait_key("k1", 4'h1, 4'b1110);
      press_en = 1'b0;
      wait_leave("k1_rel", 4'b1110, n);
      check("k1_pending", 32'(kif.key_valid), 32'd1);
      press_r = 2'd3; press_c = 2'd3; press_en = 1'b1;
      n = 0;
      while (kif.overrun !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ovr_set",   32'(kif.overrun), 32'd1);
      check("ovr_code",  32'(kif.key_code), 32'h1);
      check("ovr_valid", 32'(kif.key_valid), 32'd1);
      check("ovr_col",   32'(COL), 32'(4'b0111));
      check("ovr_phase", 32'(phase), 32'd0);
      press_en = 1'b0;
      wait_leave("kd_rel", 4'b0111, n);
      kif.key_ready = 1'b1;
      @(negedge clk);
      check("ovr_xfer",   32'(kif.key_valid), 32'd0);
      check("ovr_sticky", 32'(kif.overrun), 32'd1);

      // Two rows low is not a key: scanning continues
      force_val = 4'b1100; force_en = 1'b1;
      n = 0;
      while (phase != 2'd0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      exp_col = COL;
      for (int i = 0; i < 6; i++) begin
         repeat (4) @(negedge clk);
         exp_col = rotl(exp_col);
         check("two_row_col",   32'(COL), 32'(exp_col));
         check("two_row_valid", 32'(kif.key_valid), 32'd0);
      end
      force_en = 1'b0;

      // Reset clears overrun; then keys 1,2,3,A in order
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst2_col",     32'(COL), 32'(4'b1110));
      check("rst2_overrun", 32'(kif.overrun), 32'd0);
      check("rst2_valid",   32'(kif.key_valid), 32'd0);
      for (int c = 0; c < 3; c++) begin
         press_r = 2'd0; press_c = 2'(c); press_en = 1'b1;
         wait_key($sformatf("seq%0d", c), 4'(c + 1), col_of(2'(c)));
         press_en = 1'b0;
         wait_leave($sformatf("seq%0d_rel", c), col_of(2'(c)), n);
      end
      press_r = 2'd0; press_c = 2'd3; press_en = 1'b1;
      wait_key("kA", 4'hA, 4'b0111);
`ifdef KEYPAD_WORD_EN
      check("word_123A", kif.word, 32'h0000_123A);
`endif

      // Reset while the key is still held (HELD state)
      repeat (3) @(negedge clk);
      check("held_frozen", 32'(COL), 32'(4'b0111));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      press_en = 1'b0;
      check("held_rst_col",   32'(COL), 32'(4'b1110));
      check("held_rst_valid", 32'(kif.key_valid), 32'd0);
`ifdef KEYPAD_WORD_EN
      check("held_rst_word",  kif.word, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
